fifo_rd_packer: RTL and testbench

Read-side consumer of the asynchronous FIFO, running entirely in the read clock domain. It pops DATA_LEN-bit words from the FIFO read port and packs PACK consecutive words into one wide word, with the first word in the least significant lane. The packed word is presented on a valid/ready output stream. It is the stage directly downstream of the FIFO and feeds wide-bus consumers.

---
 rtl/fifo_rd_packer.sv | 116 +++++++++++
 tb/tb_fifo_rd_packer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_packer.sv
// Read-domain packer: pops DATA_LEN-bit words from the async FIFO and emits PACK of them per
// valid/ready output word, first word in lane 0. Partial-word flush is built with FIFO_RD_PACKER_FLUSH_EN.
`timescale 1ns/1ps

module fifo_rd_packer #(
  parameter int DATA_LEN = 8,
  parameter int PACK     = 4
) (
  input  logic                     rd_clk,
  input  logic                     rd_rstn,
  output logic                     fifo_rd_en,
  input  logic                     fifo_rd_empty,
  input  logic [DATA_LEN-1:0]      fifo_rd_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_LEN*PACK-1:0] out_data,
  output logic [PACK-1:0]          out_keep,
  input  logic                     flush,
  output logic [15:0]              word_cnt
);

  localparam int              CW       = $clog2(PACK + 1);
  localparam logic [CW:0]     PACK_EXT = (CW+1)'(PACK);
  localparam logic [CW-1:0]   PACK_CNT = CW'(PACK);

  logic                     run;
  logic                     inflight;
  logic                     flush_pend;
  logic [CW-1:0]            acc_cnt;
  logic [CW-1:0]            acc_cnt_l;
  logic [DATA_LEN*PACK-1:0] acc_data;
  logic [DATA_LEN*PACK-1:0] acc_data_l;
  logic [PACK-1:0]          lane_mask;
  logic [CW:0]              claimed;
  logic                     land;
  logic                     hs;
  logic                     out_free;
  logic                     acc_full;
  logic                     flush_done;
  logic                     load;

  // Every pop lands exactly one edge later, so the inflight flag doubles as the landing strobe.
  assign land     = inflight;
  assign hs       = out_valid && out_ready;
  assign out_free = !out_valid || out_ready;

  // Lanes already filled plus the one in flight must leave room before another pop is allowed.
  assign claimed    = {1'b0, acc_cnt} + {{CW{1'b0}}, inflight};
  assign fifo_rd_en = run && !fifo_rd_empty && !flush_pend && (claimed < PACK_EXT);

  // acc as it stands once this edge's landing (if any) is included.
  assign acc_cnt_l = acc_cnt + {{(CW-1){1'b0}}, land};

  always_comb begin
    // NOTE: defaults first so every path assigns the comb outputs and no latch is inferred.
    acc_data_l = acc_data;
    lane_mask  = '0;
    for (int k = 0; k < PACK; k++) begin
      if (land && acc_cnt == CW'(k)) acc_data_l[k*DATA_LEN +: DATA_LEN] = fifo_rd_data;
      lane_mask[k] = CW'(k) < acc_cnt_l;
    end
  end

  assign acc_full   = acc_cnt_l == PACK_CNT;
  assign flush_done = flush_pend && !inflight && out_free;
  assign load       = (out_free && acc_full) || (flush_done && acc_cnt != '0);

`ifdef FIFO_RD_PACKER_FLUSH_EN
  always_ff @(posedge rd_clk or negedge rd_rstn) begin
    if (!rd_rstn) flush_pend <= 1'b0;
    else          flush_pend <= flush || (flush_pend && !flush_done);
  end
`else
  logic unused_flush;
  assign unused_flush = flush;
  assign flush_pend   = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge rd_clk or negedge rd_rstn) begin
    if (!rd_rstn) begin
      run       <= 1'b0;
      inflight  <= 1'b0;
      // NOTE: acc is a few flops, not a RAM, so it is reset; a stale partial must never leak out.
      acc_data  <= '0;
      acc_cnt   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
      word_cnt  <= '0;
    end else begin
      run      <= 1'b1;
      inflight <= fifo_rd_en;

      // Clearing acc on a move keeps lanes above a later partial fill at zero.
      if (load) begin
        acc_data <= '0;
        acc_cnt  <= '0;
      end else begin
        acc_data <= acc_data_l;
        acc_cnt  <= acc_cnt_l;
      end

      if (load) begin
        out_valid <= 1'b1;
        out_data  <= acc_data_l;
        out_keep  <= lane_mask;
      end else if (hs) begin
        out_valid <= 1'b0;
      end

      if (hs) word_cnt <= word_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Self-checking bench for fifo_rd_packer: FIFO model, handshake monitor, spec-level word model,
// table vectors, directed corner sequences and a randomized stream.
`timescale 1ns/1ps

module tb_fifo_rd_packer;

  localparam int DEPTH = 1024;
  localparam int R     = 40;

  logic        rd_clk = 1'b0;
  logic        rd_rstn;
  logic        fifo_rd_en;
  logic        fifo_rd_empty;
  logic [7:0]  fifo_rd_data = '0;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        flush;
  logic [15:0] word_cnt;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  logic [7:0] mem [DEPTH];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int model_base = 0;

  logic [35:0] hs_q [$];
  int          hs_cyc [$];
  logic        stall_prev = 1'b0;
  logic [35:0] held = '0;

  typedef struct {
    logic [7:0]  w [4];
    logic [31:0] exp_data;
    logic [3:0]  exp_keep;
  } vec_t;

  fifo_rd_packer #(.DATA_LEN(8), .PACK(4)) dut (
    .rd_clk        (rd_clk),
    .rd_rstn       (rd_rstn),
    .fifo_rd_en    (fifo_rd_en),
    .fifo_rd_empty (fifo_rd_empty),
    .fifo_rd_data  (fifo_rd_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_keep      (out_keep),
    .flush         (flush),
    .word_cnt      (word_cnt)
  );

  always #5 rd_clk = ~rd_clk;
  always @(posedge rd_clk) cyc <= cyc + 1;

  // FIFO model: data appears one edge after the pop that sampled rd_en && !empty.
  assign fifo_rd_empty = (rd_ptr == wr_ptr);
  always @(posedge rd_clk) begin
    if (fifo_rd_en && !fifo_rd_empty) begin
      fifo_rd_data <= mem[rd_ptr % DEPTH];
      rd_ptr       <= rd_ptr + 1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: records handshakes and checks the output register holds still under backpressure.
  always @(negedge rd_clk) begin
    if (!rd_rstn) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", {63'd0, out_valid}, 64'd1);
        check("hold_word", {28'd0, out_keep, out_data}, {28'd0, held});
      end
      if (out_valid && out_ready) begin
        hs_q.push_back({out_keep, out_data});
        hs_cyc.push_back(cyc);
      end
      stall_prev = out_valid && !out_ready;
      held       = {out_keep, out_data};
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge rd_clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] w);
    mem[wr_ptr % DEPTH] = w;
    wr_ptr++;
  endtask

  task automatic get_hs(input string name, output logic [35:0] e, output int c);
    int waited = 0;
    e = '0;
    c = -1;
    while (hs_q.size() == 0 && waited < 300) begin
      tick(1);
      waited++;
    end
    if (hs_q.size() == 0) begin
      total++;
      $display("FAIL %s: no output word within %0d cycles", name, waited);
    end else begin
      e = hs_q.pop_front();
      c = hs_cyc.pop_front();
    end
  endtask

  // Spec model: an output word is the next n pushed words, oldest in lane 0, unused lanes zero.
  function automatic logic [35:0] model_word(input int base, input int n);
    logic [31:0] d = '0;
    logic [3:0]  k = '0;
    for (int i = 0; i < n; i++) begin
      d[i*8 +: 8] = mem[(base + i) % DEPTH];
      k[i]        = 1'b1;
    end
    return {k, d};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t        vecs [3];
    logic [35:0] e;
    int          c, c0, c1, p0;

    vecs[0].w = '{8'h00, 8'hFF, 8'h00, 8'hFF}; vecs[0].exp_data = 32'hFF00FF00; vecs[0].exp_keep = 4'hF;
    vecs[1].w = '{8'hDE, 8'hAD, 8'hBE, 8'hEF}; vecs[1].exp_data = 32'hEFBEADDE; vecs[1].exp_keep = 4'hF;
    vecs[2].w = '{8'h01, 8'h02, 8'h04, 8'h80}; vecs[2].exp_data = 32'h80040201; vecs[2].exp_keep = 4'hF;

    rd_rstn   = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    tick(3);
    for (int i = 1; i <= 8; i++) push(8'((i << 4) | i));

    check("rst_rd_en", {63'd0, fifo_rd_en}, 64'd0);
    check("rst_valid", {63'd0, out_valid}, 64'd0);
    check("rst_data", {32'd0, out_data}, 64'd0);
    check("rst_keep", {60'd0, out_keep}, 64'd0);
    check("rst_word_cnt", {48'd0, word_cnt}, 64'd0);

    // Streaming, including first-pop and output latency.
    out_ready = 1'b1;
    rd_rstn   = 1'b1;
    c0 = cyc;
    #1;
    check("first_edge_no_pop", {63'd0, fifo_rd_en}, 64'd0);
    tick(1);
    check("second_edge_pop", {63'd0, fifo_rd_en}, 64'd1);
    get_hs("stream0", e, c1);
    check("stream0_word", {28'd0, e}, {28'd0, 4'hF, 32'h44332211});
    check("stream0_latency", 64'(c1 - c0), 64'd6);
    get_hs("stream1", e, c);
    check("stream1_word", {28'd0, e}, {28'd0, 4'hF, 32'h88776655});
    check("stream_spacing", 64'(c - c1), 64'd5);
    tick(2);
    check("stream_word_cnt", {48'd0, word_cnt}, 64'd2);
    model_base += 8;

    // Table vectors.
    for (int v = 0; v < 3; v++) begin
      for (int i = 0; i < 4; i++) push(vecs[v].w[i]);
      get_hs($sformatf("vec%0d", v), e, c);
      check($sformatf("vec%0d_data", v), {32'd0, e[31:0]}, {32'd0, vecs[v].exp_data});
      check($sformatf("vec%0d_keep", v), {60'd0, e[35:32]}, {60'd0, vecs[v].exp_keep});
      model_base += 4;
    end

    // Backpressure: one word in out, one in acc, then nothing more is popped.
    out_ready = 1'b0;
    tick(2);
    p0 = rd_ptr;
    for (int i = 0; i < 12; i++) push(8'($urandom_range(0, 255)));
    tick(40);
    check("bp_pops", 64'(rd_ptr - p0), 64'd8);
    check("bp_valid", {63'd0, out_valid}, 64'd1);
    check("bp_frozen_word", {28'd0, out_keep, out_data}, {28'd0, model_word(model_base, 4)});
    check("bp_no_hs", 64'(hs_q.size()), 64'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      get_hs($sformatf("bp_drain%0d", k), e, c);
      check($sformatf("bp_drain%0d_word", k), {28'd0, e}, {28'd0, model_word(model_base, 4)});
      model_base += 4;
    end
    check("bp_total_pops", 64'(rd_ptr - p0), 64'd12);

    // Partial word is held while the FIFO is empty.
    push(8'hA1); push(8'hB2); push(8'hC3);
    tick(50);
    check("partial_no_hs", 64'(hs_q.size()), 64'd0);
    check("partial_no_valid", {63'd0, out_valid}, 64'd0);
    push(8'hD4);
    get_hs("partial_done", e, c);
    check("partial_done_word", {28'd0, e}, {28'd0, 4'hF, 32'hD4C3B2A1});
    model_base += 4;

    // Flush.
    push(8'h01); push(8'h02);
    tick(10);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
`ifdef FIFO_RD_PACKER_FLUSH_EN
    get_hs("flush_partial", e, c);
    check("flush_partial_word", {28'd0, e}, {28'd0, 4'h3, 32'h00000201});
    model_base += 2;
    push(8'h31); push(8'h32); push(8'h33); push(8'h34);
    get_hs("flush_next", e, c);
    check("flush_next_word", {28'd0, e}, {28'd0, 4'hF, 32'h34333231});
    model_base += 4;
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    tick(20);
    check("flush_empty_no_hs", 64'(hs_q.size()), 64'd0);
    check("flush_empty_no_valid", {63'd0, out_valid}, 64'd0);
`else
    tick(30);
    check("noflush_no_hs", 64'(hs_q.size()), 64'd0);
    check("noflush_no_valid", {63'd0, out_valid}, 64'd0);
    push(8'h03); push(8'h04);
    get_hs("noflush_full", e, c);
    check("noflush_full_word", {28'd0, e}, {28'd0, 4'hF, 32'h04030201});
    model_base += 4;
`endif

    // Reset mid-operation with two words sitting in acc.
    push(8'hE1); push(8'hE2);
    tick(10);
    @(posedge rd_clk);
    #3;
    rd_rstn = 1'b0;
    #1;
    check("midrst_rd_en", {63'd0, fifo_rd_en}, 64'd0);
    check("midrst_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_data", {32'd0, out_data}, 64'd0);
    check("midrst_keep", {60'd0, out_keep}, 64'd0);
    check("midrst_word_cnt", {48'd0, word_cnt}, 64'd0);
    model_base = rd_ptr;
    push(8'hF0); push(8'hF1); push(8'hF2); push(8'hF3);
    tick(2);
    rd_rstn = 1'b1;
    #1;
    check("midrst_first_edge_no_pop", {63'd0, fifo_rd_en}, 64'd0);
    tick(1);
    check("midrst_second_edge_pop", {63'd0, fifo_rd_en}, 64'd1);
    get_hs("midrst_word", e, c);
    check("midrst_word_val", {28'd0, e}, {28'd0, 4'hF, 32'hF3F2F1F0});
    model_base += 4;
    tick(2);
    check("midrst_word_cnt_after", {48'd0, word_cnt}, 64'd1);

    // Randomized pushes and backpressure against the word model.
    begin
      int pushed = 0;
      while (pushed < 4 * R) begin
        out_ready = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 1) == 1) begin
          push(8'($urandom_range(0, 255)));
          pushed++;
        end
        tick(1);
      end
    end
    out_ready = 1'b1;
    for (int r = 0; r < R; r++) begin
      get_hs($sformatf("rand%0d", r), e, c);
      check($sformatf("rand%0d_word", r), {28'd0, e}, {28'd0, model_word(model_base, 4)});
      model_base += 4;
    end
    tick(10);
    check("rand_no_extra_hs", 64'(hs_q.size()), 64'd0);
    check("rand_word_cnt", {48'd0, word_cnt}, 64'(1 + R));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
